// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned MAX_WAIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StBubble  = 2'd1,
    StMemWait = 2'd2,
    StError   = 2'd3
  } state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Five-stage pipeline stall/flush controller: load-use bubbles, branch flushes,
// data-memory wait freezing with timeout, and stall-cycle statistics.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT    = MAX_WAIT_DEFAULT,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   pick_bubble,
  input  logic                   branch_taken,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_write,
  output logic                   mem_wb_write,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);

  state_e           state_d, state_q;
  logic [WaitW-1:0] wait_d, wait_q;
  logic             timeout_d, timeout_q;
  logic             mem_busy;

  assign mem_busy = dmem_req & ~dmem_ready;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;

    unique case (state_q)
      StRun, StBubble: begin
        if (mem_busy) begin
          wait_d  = WaitW'(1);
          state_d = StMemWait;
        end else if (branch_taken) begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_write = 1'b1;
          mem_wb_write = 1'b1;
          state_d      = StRun;
        end else if (!pick_bubble && (state_q == StRun)) begin
          // Only one bubble per load-use: BUBBLE ignores the hazard line.
          id_ex_flush  = 1'b1;
          ex_mem_write = 1'b1;
          mem_wb_write = 1'b1;
          state_d      = StBubble;
        end else begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          ex_mem_write = 1'b1;
          mem_wb_write = 1'b1;
          state_d      = StRun;
        end
      end
      StMemWait: begin
        if ((wait_q == MaxWait) && !dmem_ready) begin
          timeout_d = 1'b1;
          state_d   = StError;
        end else if (mem_busy) begin
          wait_d = wait_q + WaitW'(1);
        end else begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          ex_mem_write = 1'b1;
          mem_wb_write = 1'b1;
          wait_d       = '0;
          state_d      = StRun;
        end
      end
      StError: begin
        timeout_d = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (!arst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= StRun;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

  sat_counter #(
    .Width(STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .inc   (~pc_write),
    .count (stall_cnt)
  );

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum data-memory wait cycles before a timeout is declared.
REQ-002 Parameter STALL_CNT_W, default 16: width of the stall statistics counter.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 arst_n  input  1  asynchronous, active-low reset.
REQ-005 pick_bubble  input  1  load-use hazard indication from hazard detection: 0 = hazard (insert bubble), 1 = no hazard.
REQ-006 branch_taken  input  1  branch/jump resolved taken in EX; younger instructions must be flushed.
REQ-007 dmem_req  input  1  MEM stage has an outstanding data-memory access this cycle.
REQ-008 dmem_ready  input  1  data memory completes the access this cycle.
REQ-009 pc_write  output  1  PC register write enable.
REQ-010 if_id_write  output  1  IF/ID register write enable.
REQ-011 if_id_flush  output  1  IF/ID register loads a NOP.
REQ-012 id_ex_flush  output  1  ID/EX register loads a bubble (all control zero).
REQ-013 ex_mem_write  output  1  EX/MEM register write enable.
REQ-014 mem_wb_write  output  1  MEM/WB register write enable.
REQ-015 mem_timeout  output  1  sticky error flag: memory wait exceeded MAX_WAIT.
REQ-016 stall_cnt  output  STALL_CNT_W  saturating count of cycles with pc_write = 0.

Function
REQ-017 The FSM SHALL have four states: RUN, BUBBLE, MEM_WAIT, ERROR.
REQ-018 Outputs SHALL be combinational from the current state and inputs (same-cycle effect); state, wait counter, stall_cnt and mem_timeout SHALL be registered.
REQ-019 Define mem_busy = dmem_req & ~dmem_ready; priority within a cycle: mem_busy > branch_taken > load-use (pick_bubble = 0).
REQ-020 RUN, no event: all write enables 1, both flushes 0; next state RUN.
REQ-021 RUN with mem_busy: all four write enables and pc_write 0, flushes 0; wait counter loads 1; next state MEM_WAIT.
REQ-022 RUN with branch_taken (no mem_busy): pc_write, if_id_write, ex_mem_write, mem_wb_write 1; if_id_flush and id_ex_flush 1; next state RUN.
REQ-023 RUN with pick_bubble = 0 (no higher-priority event): pc_write 0, if_id_write 0, id_ex_flush 1, ex_mem_write 1, mem_wb_write 1; next state BUBBLE.
REQ-024 BUBBLE: pick_bubble SHALL be ignored (exactly one bubble per load-use); otherwise behaves as RUN for mem_busy and branch_taken; next state per RUN rules, RUN when no event.
REQ-025 MEM_WAIT with mem_busy: all write enables 0, flushes 0; wait counter increments; branch_taken ignored (held by frozen EX).
REQ-026 MEM_WAIT with dmem_ready = 1: outputs as RUN no-event this cycle, wait counter clears; next state RUN.
REQ-027 MEM_WAIT when wait counter = MAX_WAIT and dmem_ready = 0: mem_timeout sets to 1; next state ERROR.
REQ-028 ERROR: all write enables 0, flushes 0; stays until reset; mem_timeout held 1.
REQ-029 stall_cnt SHALL increment on every cycle with pc_write = 0 and saturate at all-ones (no wrap).
REQ-030 Wait counter width SHALL be $clog2(MAX_WAIT+1); it SHALL never exceed MAX_WAIT.

Reset
REQ-031 While arst_n = 0: state RUN, wait counter 0, stall_cnt 0, mem_timeout 0; all write enables and flushes forced 0.
REQ-032 Reset asserted mid-MEM_WAIT or in ERROR SHALL return to RUN and clear mem_timeout immediately, without waiting for a clock edge.

Structure
REQ-033 The state encoding enum and MAX_WAIT default SHALL live in the shared pipeline package.
REQ-034 The saturating stall counter SHALL be one sub-module, sat_counter, parameterised by width.

Verification
REQ-035 RUN, pick_bubble = 0 for 2 consecutive cycles -> cycle 1: pc_write = 0, if_id_write = 0, id_ex_flush = 1; cycle 2: all enables 1; stall_cnt = 1.
REQ-036 dmem_req = 1, dmem_ready low 3 cycles then high -> 3 frozen cycles, enables all 1 in ready cycle, stall_cnt = 3, back to RUN.
REQ-037 branch_taken = 1 with pick_bubble = 0 same cycle -> if_id_flush = 1, id_ex_flush = 1, pc_write = 1, no BUBBLE entry.
REQ-038 dmem_req = 1, dmem_ready = 0 for 20 cycles (MAX_WAIT = 15) -> mem_timeout = 1 after 15th wait cycle, all enables 0 thereafter.
REQ-039 arst_n pulsed low in ERROR -> mem_timeout = 0, stall_cnt = 0 asynchronously; after release, enables 1.
REQ-040 STALL_CNT_W = 4, 20 continuous stall cycles -> stall_cnt saturates at 15.
